multicycle_control: RTL and testbench

Main control FSM for the multicycle RV32I core. It sequences the shared ALU, register file, instruction register and unified memory port across the FETCH/DECODE/EXECUTE/MEM/WB steps. Per state it drives aluop, ALU operand selects, result-mux select and all write enables. aluop feeds alu_control unchanged. It also keeps a retired-instruction counter.

---
 rtl/riscv_ctrl_pkg.sv | 44 ++++
 rtl/instret_counter.sv | 21 ++
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path:
// FSM states, opcodes and datapath select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/instret_counter.sv
// Retired-instruction counter; wraps modulo 2^W.
module instret_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  // count one per retire, natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else if (en_i) count_q <= count_q + W'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences
// fetch/decode/execute/memory/writeback and counts retires.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter bit WAIT_MEM  = 1'b1,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic                 funct3_0,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_we,
  output logic                 ir_we,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 reg_we,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           aluop,
  output logic [1:0]           result_src,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state_dbg
);

  state_t state_q, state_d;
  logic   illegal_q;
  logic   rdy;
  logic   retire;

  // memory completion; forced when memory is single-cycle
  assign rdy = WAIT_MEM ? mem_ready : 1'b1;

  // state register, async reset to BOOT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_BOOT;
    else     state_q <= state_d;
  end

  // next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXEC_R;
          OP_ITYPE:  state_d = S_EXEC_I;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (rdy) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (rdy) state_d = S_FETCH;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_BOOT;
    endcase
  end

  // per-state output decode; only mem handshake and branch are Mealy
  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    aluop      = ALUOP_ADD;
    result_src = RES_ALUOUT;
    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_4;
        result_src = RES_ALU;
        pc_we      = rdy;
        ir_we      = rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        result_src = RES_MEM;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        aluop     = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: reg_we = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        aluop     = ALUOP_SUB;
        pc_we     = zero ^ funct3_0;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_4;
        pc_we     = 1'b1;
      end
      default: ;
    endcase
  end

  // sticky illegal flag, raised as the FSM enters TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else if (state_d == S_TRAP) illegal_q <= 1'b1;
  end

  // retire on every exit back to FETCH (JAL retires via ALUWB)
  assign retire = (state_q == S_MEMWB) ||
                  (state_q == S_ALUWB) ||
                  (state_q == S_BRANCH) ||
                  ((state_q == S_MEMWR) && rdy);

  instret_counter #(
    .W (INSTRET_W)
  ) u_instret (
    .clk     (clk),
    .rst     (rst),
    .en_i    (retire),
    .count_o (instret)
  );

  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table through
// a scoreboard queue, plus reset/wrap corner sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       funct3_0 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, ir_we, mem_req, mem_we, iord, reg_we;
  logic [1:0] alu_src_a, alu_src_b, aluop, result_src;
  logic       illegal;
  logic [7:0] instret;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_control #(
    .WAIT_MEM  (1'b1),
    .INSTRET_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct3_0   (funct3_0),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_we      (pc_we),
    .ir_we      (ir_we),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .reg_we     (reg_we),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .aluop      (aluop),
    .result_src (result_src),
    .illegal    (illegal),
    .instret    (instret),
    .state_dbg  (state_dbg)
  );

  localparam logic [6:0] R  = 7'h33;
  localparam logic [6:0] LD = 7'h03;
  localparam logic [6:0] SW = 7'h23;
  localparam logic [6:0] IT = 7'h13;
  localparam logic [6:0] BR = 7'h63;
  localparam logic [6:0] JL = 7'h6f;
  localparam logic [6:0] BD = 7'h7f;

  localparam logic [3:0] BOOT = 4'd0, FET = 4'd1, DEC = 4'd2;
  localparam logic [3:0] MAD = 4'd3, MRD = 4'd4, MWB = 4'd5;
  localparam logic [3:0] MWR = 4'd6, EXR = 4'd7, EXI = 4'd8;
  localparam logic [3:0] AWB = 4'd9, BRS = 4'd10, JAS = 4'd11;
  localparam logic [3:0] TRP = 4'd12;

  // {pc,ir,req,we,iord,rwe,a[2],b[2],aluop[2],res[2]}
  localparam logic [13:0] O_0    = 14'b0;
  localparam logic [13:0] O_FET  = 14'b1_1_1_0_0_0_00_10_00_10;
  localparam logic [13:0] O_FETW = 14'b0_0_1_0_0_0_00_10_00_10;
  localparam logic [13:0] O_DEC  = 14'b0_0_0_0_0_0_01_01_00_00;
  localparam logic [13:0] O_MAD  = 14'b0_0_0_0_0_0_10_01_00_00;
  localparam logic [13:0] O_MRD  = 14'b0_0_1_0_1_0_00_00_00_00;
  localparam logic [13:0] O_MWB  = 14'b0_0_0_0_0_1_00_00_00_01;
  localparam logic [13:0] O_MWR  = 14'b0_0_1_1_1_0_00_00_00_00;
  localparam logic [13:0] O_EXR  = 14'b0_0_0_0_0_0_10_00_10_00;
  localparam logic [13:0] O_EXI  = 14'b0_0_0_0_0_0_10_01_10_00;
  localparam logic [13:0] O_AWB  = 14'b0_0_0_0_0_1_00_00_00_00;
  localparam logic [13:0] O_BRT  = 14'b1_0_0_0_0_0_10_00_01_00;
  localparam logic [13:0] O_BRN  = 14'b0_0_0_0_0_0_10_00_01_00;
  localparam logic [13:0] O_JAL  = 14'b1_0_0_0_0_0_01_10_00_00;

  typedef struct {
    int          id;
    logic [6:0]  op;
    logic        f3;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [13:0] outs;
    logic [7:0]  ic;
    logic        ill;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t e;
  int   checks = 0;
  int   failures = 0;
  int   nid = 0;

  logic [13:0] outs_act;
  assign outs_act = {pc_we, ir_we, mem_req, mem_we, iord, reg_we,
                     alu_src_a, alu_src_b, aluop, result_src};

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d act=%h exp=%h", nm, id, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [6:0] op, input logic f3,
                             input logic z, input logic rdy,
                             input logic [3:0] st, input logic [13:0] o,
                             input logic [7:0] ic, input logic ill);
    vec_t r;
    r.id = 0; r.op = op; r.f3 = f3; r.z = z; r.rdy = rdy;
    r.st = st; r.outs = o; r.ic = ic; r.ill = ill;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    x.id = nid;
    nid++;
    opcode = x.op;
    funct3_0 = x.f3;
    zero = x.z;
    mem_ready = x.rdy;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("state", e.id, 32'(state_dbg), 32'(e.st));
      chk("outs", e.id, 32'(outs_act), 32'(e.outs));
      chk("instret", e.id, 32'(instret), 32'(e.ic));
      chk("illegal", e.id, 32'(illegal), 32'(e.ill));
    end
  end

  initial begin
    // R-type
    tbl.push_back(v(R, 0, 0, 1, BOOT, O_0, 0, 0));
    tbl.push_back(v(R, 0, 0, 1, FET, O_FET, 0, 0));
    tbl.push_back(v(R, 0, 1, 0, DEC, O_DEC, 0, 0));
    tbl.push_back(v(R, 0, 0, 1, EXR, O_EXR, 0, 0));
    tbl.push_back(v(R, 0, 0, 0, AWB, O_AWB, 0, 0));
    // load with two wait cycles
    tbl.push_back(v(LD, 0, 0, 1, FET, O_FET, 1, 0));
    tbl.push_back(v(LD, 0, 0, 1, DEC, O_DEC, 1, 0));
    tbl.push_back(v(LD, 0, 0, 1, MAD, O_MAD, 1, 0));
    tbl.push_back(v(LD, 0, 0, 0, MRD, O_MRD, 1, 0));
    tbl.push_back(v(LD, 0, 0, 0, MRD, O_MRD, 1, 0));
    tbl.push_back(v(LD, 0, 0, 1, MRD, O_MRD, 1, 0));
    tbl.push_back(v(LD, 0, 0, 0, MWB, O_MWB, 1, 0));
    // BEQ taken, then BNE not taken
    tbl.push_back(v(BR, 0, 1, 1, FET, O_FET, 2, 0));
    tbl.push_back(v(BR, 0, 1, 1, DEC, O_DEC, 2, 0));
    tbl.push_back(v(BR, 0, 1, 1, BRS, O_BRT, 2, 0));
    tbl.push_back(v(BR, 1, 1, 1, FET, O_FET, 3, 0));
    tbl.push_back(v(BR, 1, 1, 1, DEC, O_DEC, 3, 0));
    tbl.push_back(v(BR, 1, 1, 1, BRS, O_BRN, 3, 0));
    // JAL
    tbl.push_back(v(JL, 0, 0, 1, FET, O_FET, 4, 0));
    tbl.push_back(v(JL, 0, 0, 1, DEC, O_DEC, 4, 0));
    tbl.push_back(v(JL, 0, 0, 1, JAS, O_JAL, 4, 0));
    tbl.push_back(v(JL, 0, 0, 1, AWB, O_AWB, 4, 0));
    // I-type
    tbl.push_back(v(IT, 0, 0, 1, FET, O_FET, 5, 0));
    tbl.push_back(v(IT, 0, 0, 1, DEC, O_DEC, 5, 0));
    tbl.push_back(v(IT, 0, 0, 1, EXI, O_EXI, 5, 0));
    tbl.push_back(v(IT, 0, 0, 1, AWB, O_AWB, 5, 0));
    // store behind a stalled fetch
    tbl.push_back(v(SW, 0, 0, 0, FET, O_FETW, 6, 0));
    tbl.push_back(v(SW, 0, 0, 1, FET, O_FET, 6, 0));
    tbl.push_back(v(SW, 0, 0, 1, DEC, O_DEC, 6, 0));
    tbl.push_back(v(SW, 0, 0, 1, MAD, O_MAD, 6, 0));
    tbl.push_back(v(SW, 0, 0, 1, MWR, O_MWR, 6, 0));
    // illegal opcode
    tbl.push_back(v(BD, 0, 0, 1, FET, O_FET, 7, 0));
    tbl.push_back(v(BD, 0, 0, 1, DEC, O_DEC, 7, 0));
    tbl.push_back(v(BD, 0, 1, 1, TRP, O_0, 7, 1));
    tbl.push_back(v(R, 0, 1, 1, TRP, O_0, 7, 1));
    tbl.push_back(v(R, 1, 0, 0, TRP, O_0, 7, 1));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 0, 32'(state_dbg), 32'(BOOT));
    chk("rst_outs", 0, 32'(outs_act), 32'(O_0));
    chk("rst_instret", 0, 32'(instret), 32'd0);
    chk("rst_illegal", 0, 32'(illegal), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // leave TRAP only through reset
    rst = 1'b1;
    #1;
    chk("trap_rst_state", nid, 32'(state_dbg), 32'(BOOT));
    chk("trap_rst_illegal", nid, 32'(illegal), 32'd0);
    chk("trap_rst_instret", nid, 32'(instret), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // retire 255 branches to sit one below the 8-bit wrap
    drive(v(BR, 0, 0, 1, BOOT, O_0, 0, 0));
    for (int k = 0; k < 255; k++) begin
      logic z;
      z = k[0];
      drive(v(BR, 0, z, 1, FET, O_FET, 8'(k), 0));
      drive(v(BR, 0, z, 1, DEC, O_DEC, 8'(k), 0));
      drive(v(BR, 0, z, 1, BRS, z ? O_BRT : O_BRN, 8'(k), 0));
    end
    chk("pre_wrap", nid, 32'(instret), 32'd255);

    // store retires across the wrap
    drive(v(SW, 0, 0, 1, FET, O_FET, 255, 0));
    drive(v(SW, 0, 0, 1, DEC, O_DEC, 255, 0));
    drive(v(SW, 0, 0, 1, MAD, O_MAD, 255, 0));
    drive(v(SW, 0, 0, 1, MWR, O_MWR, 255, 0));

    // second store stalls in MEMWR, then reset lands mid-cycle
    drive(v(SW, 0, 0, 1, FET, O_FET, 0, 0));
    drive(v(SW, 0, 0, 1, DEC, O_DEC, 0, 0));
    drive(v(SW, 0, 0, 1, MAD, O_MAD, 0, 0));
    drive(v(SW, 0, 0, 0, MWR, O_MWR, 0, 0));
    mem_ready = 1'b0;
    #1;
    chk("hold_state", nid, 32'(state_dbg), 32'(MWR));
    chk("hold_req", nid, 32'(mem_req), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_req", nid, 32'(mem_req), 32'd0);
    chk("async_outs", nid, 32'(outs_act), 32'(O_0));
    chk("async_state", nid, 32'(state_dbg), 32'(BOOT));
    chk("async_instret", nid, 32'(instret), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_state", nid, 32'(state_dbg), 32'(FET));
    chk("post_rst_instret", nid, 32'(instret), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
